// File: rtl/sep_blur_engine.sv
// Separable binomial blur: a horizontal pass fills a KSIZE-row line buffer, then a
// vertical pass produces one blurred row of COLS pixels per accepted padded input row.
module sep_blur_engine #(
    parameter int PIX_W = 8,
    parameter int COLS  = 16,
    parameter int KSIZE = 5,
    parameter int LANES = 2
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [(COLS+KSIZE-1)*PIX_W-1:0] row_in,
    input  logic                            row_valid,
    output logic                            row_ready,
    input  logic                            frame_start,
    input  logic                            bypass,
    output logic [COLS*PIX_W-1:0]           out_row,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int N      = COLS / LANES;
    localparam int S      = (KSIZE == 3) ? 2 : 4;
    localparam int P      = (KSIZE - 1) / 2;
    localparam int IN_PIX = COLS + KSIZE - 1;
    localparam int ACC_W  = PIX_W + S + 1;
    localparam int RND    = 1 << (S - 1);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, HPASS, VPASS, HOLD} state_t;

    function automatic logic [ACC_W-1:0] coef(input int k);
        if (KSIZE == 3) begin
            return (k == 1) ? ACC_W'(2) : ACC_W'(1);
        end
        case (k)
            1, 3:    return ACC_W'(4);
            2:       return ACC_W'(6);
            default: return ACC_W'(1);
        endcase
    endfunction

    state_t                   state_reg, state_next;
    logic [IDX_W-1:0]         idx_reg;
    logic [IDX_W-1:0]         wr_idx_reg;
    logic [IN_PIX*PIX_W-1:0]  in_reg;
    logic                     fs_reg;
    logic                     byp_reg;
    logic                     vp_reg;
    logic                     out_valid_reg;
    logic [PIX_W-1:0]         line_mem [KSIZE][COLS];
    logic [PIX_W-1:0]         rd_reg [KSIZE][LANES];
    logic [PIX_W-1:0]         byp_rd_reg [LANES];
    logic [PIX_W-1:0]         out_pix_reg [COLS];
    logic [PIX_W-1:0]         h_lane [LANES];
    logic [PIX_W-1:0]         v_lane [LANES];
    logic [COL_W-1:0]         lane_col [LANES];
    logic [COL_W-1:0]         lane_wcol [LANES];

    logic accept;
    logic last_idx;
    logic h_write;
    logic v_read;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (row_valid) state_next = HPASS;
            HPASS:   if (last_idx) state_next = VPASS;
            VPASS:   if (last_idx) state_next = HOLD;
            HOLD:    if (out_valid_reg && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        row_ready = (state_reg == IDLE);
        accept    = (state_reg == IDLE) && row_valid;
        h_write   = (state_reg == HPASS) && !byp_reg;
        v_read    = (state_reg == VPASS);
    end

    assign last_idx  = (idx_reg == IDX_W'(N - 1));
    assign out_valid = out_valid_reg;

    // Lane index walks 0..N-1 through each pass and rests at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            idx_reg <= '0;
        end else if (state_reg == HPASS || state_reg == VPASS) begin
            idx_reg <= last_idx ? '0 : idx_reg + 1'b1;
        end else begin
            idx_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            in_reg  <= '0;
            fs_reg  <= 1'b0;
            byp_reg <= 1'b0;
        end else if (accept) begin
            in_reg  <= row_in;
            fs_reg  <= frame_start;
            byp_reg <= bypass;
        end
    end

    // Line buffer: row 0 is the newest horizontally filtered row.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    line_mem[r][c] <= '0;
                end
            end
        end else if (accept && !bypass) begin
            for (int r = KSIZE - 1; r > 0; r--) begin
                for (int c = 0; c < COLS; c++) begin
                    line_mem[r][c] <= line_mem[r-1][c];
                end
            end
        end else if (h_write) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < KSIZE; r++) begin
                    if (r == 0 || fs_reg) begin
                        line_mem[r][lane_col[l]] <= h_lane[l];
                    end
                end
            end
        end
    end

    // Registered read of the line buffer; the result lands one cycle later.
    always_ff @(posedge clk) begin
        if (v_read) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < KSIZE; r++) begin
                    rd_reg[r][l] <= line_mem[r][lane_col[l]];
                end
                byp_rd_reg[l] <= in_reg[(int'(lane_col[l]) + P) * PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            vp_reg     <= 1'b0;
            wr_idx_reg <= '0;
        end else begin
            vp_reg     <= v_read;
            wr_idx_reg <= idx_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int c = 0; c < COLS; c++) begin
                out_pix_reg[c] <= '0;
            end
        end else if (vp_reg) begin
            for (int l = 0; l < LANES; l++) begin
                out_pix_reg[lane_wcol[l]] <= byp_reg ? byp_rd_reg[l] : v_lane[l];
            end
        end
    end

    // The last read drains on the first HOLD edge, so valid rises one edge into HOLD.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_valid_reg <= 1'b0;
        end else if (state_reg == HOLD && vp_reg) begin
            out_valid_reg <= 1'b1;
        end else if (state_reg == HOLD && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACC_W-1:0] h_acc;
            logic [ACC_W-1:0] v_acc;

            assign lane_col[gi]  = COL_W'(int'(idx_reg) * LANES + gi);
            assign lane_wcol[gi] = COL_W'(int'(wr_idx_reg) * LANES + gi);

            always_comb begin
                h_acc = ACC_W'(RND);
                for (int k = 0; k < KSIZE; k++) begin
                    h_acc = h_acc + coef(k) *
                            ACC_W'(in_reg[(int'(lane_col[gi]) + k) * PIX_W +: PIX_W]);
                end
            end

            always_comb begin
                v_acc = ACC_W'(RND);
                for (int r = 0; r < KSIZE; r++) begin
                    v_acc = v_acc + coef(r) * ACC_W'(rd_reg[r][gi]);
                end
            end

            assign h_lane[gi] = PIX_W'(h_acc >> S);
            assign v_lane[gi] = PIX_W'(v_acc >> S);
        end

        for (gi = 0; gi < COLS; gi++) begin : g_out
            assign out_row[gi*PIX_W +: PIX_W] = out_pix_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sep_blur_engine.sv
// Bench for sep_blur_engine: directed vector table, randomized rows against a
// binomial-kernel reference model, reset and backpressure sequences, KSIZE=3 variant.
module tb_sep_blur_engine;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [159:0] row_in;
    logic         frame_start;
    logic         bypass;
    logic         row_valid_a, row_valid_b;
    logic         out_ready_a, out_ready_b;
    logic         row_ready_a, row_ready_b;
    logic         out_valid_a, out_valid_b;
    logic [127:0] out_row_a, out_row_b;

    always #5 clk = ~clk;

    sep_blur_engine #(.PIX_W(8), .COLS(16), .KSIZE(5), .LANES(2)) dut_a (
        .clk(clk), .n_rst(n_rst), .row_in(row_in), .row_valid(row_valid_a),
        .row_ready(row_ready_a), .frame_start(frame_start), .bypass(bypass),
        .out_row(out_row_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    sep_blur_engine #(.PIX_W(8), .COLS(16), .KSIZE(3), .LANES(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .row_in(row_in[143:0]), .row_valid(row_valid_b),
        .row_ready(row_ready_b), .frame_start(frame_start), .bypass(bypass),
        .out_row(out_row_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int hist [2][5][16];

    typedef struct {
        logic [159:0] inrow;
        bit           fs;
        bit           byp;
        int           hold;
        logic [127:0] expv;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic logic [159:0] const_in(input int v);
        logic [159:0] r = '0;
        for (int i = 0; i < 20; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [127:0] const_out(input int v);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? row_ready_b : row_ready_a;
    endfunction

    function automatic logic ovalid(input int sel);
        return (sel != 0) ? out_valid_b : out_valid_a;
    endfunction

    function automatic logic [127:0] orow(input int sel);
        return (sel != 0) ? out_row_b : out_row_a;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) row_valid_b = v; else row_valid_a = v;
    endtask

    task automatic set_oready(input int sel, input logic v);
        if (sel != 0) out_ready_b = v; else out_ready_a = v;
    endtask

    // Reference: binomial weights from Pascal's triangle, history as a list of rows.
    task automatic model_row(input int sel, input logic [159:0] inrow, input bit fs,
                             input bit byp, output logic [127:0] expv);
        int k, s, p, acc;
        int h [16];
        k = (sel != 0) ? 3 : 5;
        s = (k == 3) ? 2 : 4;
        p = (k - 1) / 2;
        expv = '0;
        if (byp) begin
            for (int j = 0; j < 16; j++) expv[j*8 +: 8] = inrow[(j+p)*8 +: 8];
            return;
        end
        for (int j = 0; j < 16; j++) begin
            acc = 1 << (s - 1);
            for (int i = 0; i < k; i++) acc += binom(k-1, i) * int'(inrow[(j+i)*8 +: 8]);
            h[j] = acc >> s;
        end
        for (int j = 0; j < 16; j++) begin
            if (fs) begin
                for (int r = 0; r < k; r++) hist[sel][r][j] = h[j];
            end else begin
                for (int r = k - 1; r > 0; r--) hist[sel][r][j] = hist[sel][r-1][j];
                hist[sel][0][j] = h[j];
            end
        end
        for (int j = 0; j < 16; j++) begin
            acc = 1 << (s - 1);
            for (int r = 0; r < k; r++) acc += binom(k-1, r) * hist[sel][r][j];
            expv[j*8 +: 8] = 8'(acc >> s);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 2; a++)
            for (int r = 0; r < 5; r++)
                for (int j = 0; j < 16; j++) hist[a][r][j] = 0;
    endtask

    // Offer a row, measure latency, optionally stall HOLD, then hand the result off.
    task automatic run_row(input int sel, input logic [159:0] inrow, input bit fs, input bit byp,
                           input int hold, input int exp_lat, input string tag,
                           output logic [127:0] got);
        int lat;
        bit rr_ok, st_ok;
        @(negedge clk);
        check({tag, " row_ready idle"}, 128'(rdy(sel)), 128'd1);
        row_in = inrow; frame_start = fs; bypass = byp;
        set_valid(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(sel, 1'b0);
        lat = 0; rr_ok = 1'b1;
        while (!ovalid(sel) && lat < 200) begin
            if (rdy(sel)) rr_ok = 1'b0;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " row_ready busy"}, 128'(rr_ok), 128'd1);
        got = orow(sel);
        st_ok = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!ovalid(sel) || orow(sel) !== got || rdy(sel)) st_ok = 1'b0;
        end
        if (hold > 0) check({tag, " hold stable"}, 128'(st_ok), 128'd1);
        set_oready(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_oready(sel, 1'b0);
        check({tag, " handoff valid/ready"}, {126'd0, ovalid(sel), rdy(sel)}, 128'b01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got, mexp, e;
        logic [159:0] r;
        bit fs, byp, seen;
        int hold;

        n_rst = 1'b0; row_in = '0; frame_start = 1'b0; bypass = 1'b0;
        row_valid_a = 1'b0; row_valid_b = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset row_ready", {126'd0, row_ready_a, row_ready_b}, 128'b11);
        check("reset out_valid", {126'd0, out_valid_a, out_valid_b}, 128'b00);
        check("reset out_row", out_row_a, 128'd0);
        n_rst = 1'b1;

        // Directed vectors on the default configuration.
        tbl[0] = '{const_in(100), 1'b1, 1'b0, 0, const_out(100)};
        tbl[1] = '{const_in(0), 1'b1, 1'b0, 0, const_out(0)};
        r = '0; r[6*8 +: 8] = 8'd255;
        e = '0; e[2*8 +: 8] = 8'd1; e[3*8 +: 8] = 8'd4; e[4*8 +: 8] = 8'd6;
        e[5*8 +: 8] = 8'd4; e[6*8 +: 8] = 8'd1;
        tbl[2] = '{r, 1'b0, 1'b0, 0, e};
        begin
            logic [159:0] bi;
            logic [127:0] be;
            for (int i = 0; i < 20; i++) bi[i*8 +: 8] = 8'(i);
            for (int j = 0; j < 16; j++) be[j*8 +: 8] = 8'(j + 2);
            tbl[3] = '{bi, 1'b0, 1'b1, 10, be};
        end
        e = '0; e[2*8 +: 8] = 8'd5; e[3*8 +: 8] = 8'd20; e[4*8 +: 8] = 8'd30;
        e[5*8 +: 8] = 8'd20; e[6*8 +: 8] = 8'd5;
        tbl[4] = '{r, 1'b0, 1'b0, 0, e};

        for (int t = 0; t < 5; t++) begin
            model_row(0, tbl[t].inrow, tbl[t].fs, tbl[t].byp, mexp);
            run_row(0, tbl[t].inrow, tbl[t].fs, tbl[t].byp, tbl[t].hold, 17,
                    $sformatf("vec%0d", t), got);
            check($sformatf("vec%0d out_row", t), got, tbl[t].expv);
            $display("vec%0d fs=%0d byp=%0d out_row=%0h", t, tbl[t].fs, tbl[t].byp, got);
        end

        // Randomized rows on the default configuration.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 20; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
            if (t % 7 == 3) r = const_in(255);
            fs   = (t == 0) || ($urandom_range(0, 5) == 0);
            byp  = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(0, 3);
            model_row(0, r, fs, byp, mexp);
            run_row(0, r, fs, byp, hold, 17, $sformatf("rnd%0d", t), got);
            check($sformatf("rnd%0d out_row", t), got, mexp);
            $display("rnd%0d fs=%0d byp=%0d out_row=%0h", t, fs, byp, got);
        end

        // Reset in the middle of the horizontal pass discards the row.
        @(negedge clk);
        row_in = const_in(77); frame_start = 1'b1; bypass = 1'b0; row_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        row_valid_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        model_clear();
        check("midreset row_ready", 128'(row_ready_a), 128'd1);
        check("midreset out_row", out_row_a, 128'd0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid_a) seen = 1'b1;
        end
        check("midreset no stray out_valid", 128'(seen), 128'd0);
        run_row(0, const_in(50), 1'b1, 1'b0, 0, 17, "after_reset", got);
        check("after_reset out_row", got, const_out(50));
        $display("after_reset out_row=%0h", got);

        // KSIZE=3, LANES=4 configuration.
        run_row(1, const_in(200), 1'b1, 1'b0, 0, 9, "k3_const", got);
        check("k3_const out_row", got, const_out(200));
        $display("k3_const out_row=%0h", got);
        model_row(1, const_in(0), 1'b1, 1'b0, mexp);
        run_row(1, const_in(0), 1'b1, 1'b0, 0, 9, "k3_zero", got);
        check("k3_zero out_row", got, const_out(0));
        $display("k3_zero out_row=%0h", got);
        r = '0; r[6*8 +: 8] = 8'd255;
        e = '0; e[4*8 +: 8] = 8'd16; e[5*8 +: 8] = 8'd32; e[6*8 +: 8] = 8'd16;
        model_row(1, r, 1'b0, 1'b0, mexp);
        run_row(1, r, 1'b0, 1'b0, 0, 9, "k3_impulse", got);
        check("k3_impulse out_row", got, e);
        $display("k3_impulse out_row=%0h", got);
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 20; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
            fs   = ($urandom_range(0, 4) == 0);
            byp  = ($urandom_range(0, 6) == 0);
            hold = $urandom_range(0, 2);
            model_row(1, r, fs, byp, mexp);
            run_row(1, r, fs, byp, hold, 9, $sformatf("k3_rnd%0d", t), got);
            check($sformatf("k3_rnd%0d out_row", t), got, mexp);
            $display("k3_rnd%0d fs=%0d byp=%0d out_row=%0h", t, fs, byp, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
